rotator_ctrl: RTL and testbench

//  Sequencer for the WIDTH-bit rotator. It accepts one rotate command {data, dir, amount}

---
 rtl/rotator_ctrl.sv | 131 +++++++++++++
 tb/tb_rotator_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotator_ctrl.sv
// rotator_ctrl: sequencer for an external WIDTH-bit single-step rotator.
// A command {data, dir, amount} is taken over a valid/ready handshake. The controller loads
// the rotator, pulses ena once per single-bit step, captures the rotated word and offers it
// on a valid/ready result port.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake; cmd_ready is high only when idle
//   cmd_data, cmd_dir,      word to rotate; direction (0 right, 1 left); distance in bits
//   cmd_amt
//   rot_load, rot_ena,      rotator controls (ena 01 right, 10 left, 00 hold) and load data
//   rot_data
//   rot_q                   rotator output
//   res_valid / res_ready   result handshake
//   res_data                rotated word, held until the next capture
//   busy                    high whenever a command is in flight
module rotator_ctrl #(
  parameter int unsigned WIDTH    = 100,
  parameter int unsigned AW       = 7,
  parameter int unsigned SHORTEST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [AW-1:0]    cmd_amt,
  output logic             rot_load,
  output logic [1:0]       rot_ena,
  output logic [WIDTH-1:0] rot_data,
  input  logic [WIDTH-1:0] rot_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  // One extra bit so WIDTH itself is representable next to the amount.
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] WidthC = CW'(WIDTH);
  localparam logic [CW-1:0] HalfC  = CW'(WIDTH / 2);

  typedef enum logic [2:0] {StIdle, StLoad, StRot, StCapt, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] rot_data_q, rot_data_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;

  logic [CW-1:0]    amt_ext;
  logic [CW-1:0]    amt_eff;
  logic [CW-1:0]    steps_new;
  logic             dir_new;

  // Amounts below 2*WIDTH wrap with a single subtract.
  assign amt_ext = {1'b0, cmd_amt};
  assign amt_eff = (amt_ext >= WidthC) ? (amt_ext - WidthC) : amt_ext;

  // Past the half-way point the opposite direction is shorter; a tie keeps cmd_dir.
  always_comb begin
    steps_new = amt_eff;
    dir_new   = cmd_dir;
    if ((SHORTEST != 0) && (amt_eff > HalfC)) begin
      steps_new = WidthC - amt_eff;
      dir_new   = ~cmd_dir;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dir_d      = dir_q;
    rot_data_d = rot_data_q;
    res_data_d = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          rot_data_d = cmd_data;
          count_d    = steps_new;
          dir_d      = dir_new;
          state_d    = StLoad;
        end
      end
      StLoad: state_d = (count_q != '0) ? StRot : StCapt;
      StRot: begin
        if (count_q == CW'(1)) begin
          state_d = StCapt;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      StCapt: begin
        res_data_d = rot_q;
        state_d    = StDone;
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      dir_q      <= 1'b0;
      rot_data_q <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      rot_data_q <= rot_data_d;
      res_data_q <= res_data_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rot_load  = (state_q == StLoad);
  assign rot_ena   = (state_q == StRot) ? (dir_q ? 2'b10 : 2'b01) : 2'b00;
  assign res_valid = (state_q == StDone);
  assign rot_data  = rot_data_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_rotator_ctrl.sv
// Bench for rotator_ctrl: instance 0 uses SHORTEST=1, instance 1 uses SHORTEST=0, each with
// its own behavioural rotator. Expected words are queued when a command is driven and popped
// when the result appears.
module tb_rotator_ctrl;

  localparam int unsigned W  = 100;
  localparam int unsigned AW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]         cmd_valid, cmd_ready, cmd_dir, rot_load, res_valid, res_ready, busy;
  logic [1:0][W-1:0]  cmd_data, rot_data, res_data;
  logic [1:0][AW-1:0] cmd_amt;
  logic [1:0][1:0]    rot_ena;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [W-1:0] q;

    rotator_ctrl #(
      .WIDTH   (W),
      .AW      (AW),
      .SHORTEST((g == 0) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid[g]),
      .cmd_ready(cmd_ready[g]),
      .cmd_data (cmd_data[g]),
      .cmd_dir  (cmd_dir[g]),
      .cmd_amt  (cmd_amt[g]),
      .rot_load (rot_load[g]),
      .rot_ena  (rot_ena[g]),
      .rot_data (rot_data[g]),
      .rot_q    (q),
      .res_valid(res_valid[g]),
      .res_ready(res_ready[g]),
      .res_data (res_data[g]),
      .busy     (busy[g])
    );

    // Behavioural single-step rotator.
    always_ff @(posedge clk) begin
      if (rot_load[g]) begin
        q <= rot_data[g];
      end else if (rot_ena[g] == 2'b01) begin
        q <= {q[0], q[W-1:1]};
      end else if (rot_ena[g] == 2'b10) begin
        q <= {q[W-2:0], q[W-1]};
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: rotate by amt mod W in the commanded direction, one bit at a time.
  function automatic logic [W-1:0] rot_model(input logic [W-1:0] d, input logic dir,
                                             input int amt);
    logic [W-1:0] r;
    int n;
    r = d;
    n = amt % W;
    for (int k = 0; k < n; k++) begin
      r = dir ? {r[W-2:0], r[W-1]} : {r[0], r[W-1:1]};
    end
    return r;
  endfunction

  task automatic run_cmd(input int i, input logic [W-1:0] data, input logic dir, input int amt,
                         input int exp_steps, input logic [1:0] exp_code, input int hold);
    logic [W-1:0] exp;
    int c;
    int ena_n;
    sb.push_back(rot_model(data, dir, amt));
    cmd_data[i]  = data;
    cmd_dir[i]   = dir;
    cmd_amt[i]   = AW'(amt);
    cmd_valid[i] = 1'b1;
    c = 0;
    while (!cmd_ready[i] && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chki("accept_wait", 32'(c), 32'd0);
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    chki("busy_after_accept", 32'(busy[i]), 32'd1);
    chki("ready_after_accept", 32'(cmd_ready[i]), 32'd0);
    c = 1;
    ena_n = 0;
    while (!res_valid[i] && c < 300) begin
      if (rot_load[i]) chki("load_cycle", 32'(c), 32'd1);
      if (rot_ena[i] != 2'b00) begin
        ena_n++;
        chki("ena_code", 32'(rot_ena[i]), 32'(exp_code));
        chki("load_ena_overlap", 32'(rot_load[i]), 32'd0);
      end
      @(posedge clk); #1;
      c++;
    end
    chki("ena_steps", 32'(ena_n), 32'(exp_steps));
    chki("latency", 32'(c), 32'(exp_steps + 3));
    exp = sb.pop_front();
    chk("res_data", res_data[i], exp);
    for (int k = 0; k < hold; k++) begin
      // A competing command while the result is stalled must be ignored.
      cmd_valid[i] = 1'b1;
      cmd_data[i]  = ~data;
      cmd_amt[i]   = AW'(3);
      @(posedge clk); #1;
      chki("hold_valid", 32'(res_valid[i]), 32'd1);
      chk("hold_data", res_data[i], exp);
      chki("hold_cmd_ready", 32'(cmd_ready[i]), 32'd0);
    end
    res_ready[i] = 1'b1;
    @(posedge clk); #1;
    res_ready[i] = 1'b0;
    cmd_valid[i] = 1'b0;
    chki("idle_ready", 32'(cmd_ready[i]), 32'd1);
    chki("idle_valid", 32'(res_valid[i]), 32'd0);
    chki("idle_busy", 32'(busy[i]), 32'd0);
    chk("res_data_kept", res_data[i], exp);
  endtask

  task automatic chk_reset_vals(input int i);
    chki("rst_cmd_ready", 32'(cmd_ready[i]), 32'd1);
    chki("rst_busy", 32'(busy[i]), 32'd0);
    chki("rst_res_valid", 32'(res_valid[i]), 32'd0);
    chki("rst_rot_load", 32'(rot_load[i]), 32'd0);
    chki("rst_rot_ena", 32'(rot_ena[i]), 32'd0);
    chk("rst_rot_data", rot_data[i], '0);
    chk("rst_res_data", res_data[i], '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    logic [W-1:0] one;
    p   = 100'h9_1234_5678_9ABC_DEF0_1357_2468;
    one = W'(1);
    cmd_valid = '0;
    cmd_dir   = '0;
    res_ready = '0;
    cmd_data  = '0;
    cmd_amt   = '0;

    // Power-on reset values.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic left by 1 and zero-distance.
    run_cmd(0, one, 1'b1, 1, 1, 2'b10, 0);
    chk("left1_value", res_data[0], W'(2));
    run_cmd(0, one, 1'b0, 0, 0, 2'b00, 0);

    // Left 99: shortest path is one right step; without shortest, 99 left steps.
    run_cmd(0, one, 1'b1, 99, 1, 2'b01, 0);
    chk("left99_value", res_data[0], one << 99);
    run_cmd(1, one, 1'b1, 99, 99, 2'b10, 0);
    chk("left99_long_value", res_data[1], one << 99);

    // Amount wrap, full turn, tie and shortest flips.
    run_cmd(0, p, 1'b0, 105, 5, 2'b01, 0);
    run_cmd(0, p, 1'b0, 5, 5, 2'b01, 0);
    run_cmd(0, p, 1'b1, 100, 0, 2'b00, 0);
    chk("full_turn_value", res_data[0], p);
    run_cmd(0, p, 1'b0, 50, 50, 2'b01, 0);
    run_cmd(0, p, 1'b1, 51, 49, 2'b01, 0);
    run_cmd(0, p, 1'b0, 127, 27, 2'b01, 0);
    run_cmd(1, p, 1'b0, 127, 27, 2'b01, 0);

    // Result backpressure, then an immediate follow-on command.
    run_cmd(0, p, 1'b1, 3, 3, 2'b10, 10);
    run_cmd(0, ~p, 1'b0, 7, 7, 2'b01, 0);

    // Reset in the middle of a rotation.
    cmd_data[0]  = p;
    cmd_dir[0]   = 1'b0;
    cmd_amt[0]   = AW'(40);
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chki("pre_reset_ena", 32'(rot_ena[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chki("post_reset_ready", 32'(cmd_ready[0]), 32'd1);
    run_cmd(0, p, 1'b1, 10, 10, 2'b10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
